// File: rtl/wb_core_arbiter_if.sv
// Bundle of the per-master Wishbone channels and the shared slave bus around wb_core_arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface wb_core_arbiter_if #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32
);
    localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;

    logic [NUM_MASTERS-1:0]            m_cyc_i;
    logic [NUM_MASTERS-1:0]            m_stb_i;
    logic [NUM_MASTERS-1:0]            m_we_i;
    logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_i;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_o;
    logic [NUM_MASTERS-1:0]            m_ack_o;
    logic [NUM_MASTERS-1:0]            m_err_o;

    logic                              s_cyc_o;
    logic                              s_stb_o;
    logic                              s_we_o;
    logic [SEL_WIDTH-1:0]              s_sel_o;
    logic [ADDR_WIDTH-1:0]             s_addr_o;
    logic [DATA_WIDTH-1:0]             s_data_o;
    logic [DATA_WIDTH-1:0]             s_data_i;
    logic                              s_ack_i;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_addr_i, m_data_i, s_data_i, s_ack_i,
        output m_data_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_addr_o, s_data_o
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_addr_i, m_data_i, s_data_i, s_ack_i,
        input  m_data_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_addr_o, s_data_o
    );
endinterface

// File: rtl/wb_core_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave between NUM_MASTERS masters, with a
// per-transfer ack timeout, master abort and optional registered response path.
module wb_core_arbiter #(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned RESP_REG       = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic               clk_core,
    input logic               rst_core,
    wb_core_arbiter_if.slave  wb_io
);
    localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned IDX_W     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef logic [IDX_W-1:0] idx_t;
    typedef enum logic [1:0] {StIdle, StActive, StResp} state_e;

    state_e                state_q, state_d;
    idx_t                  grant_q, grant_d;
    idx_t                  last_q, last_d;
    logic [31:0]           cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;

    logic [NUM_MASTERS-1:0] req;
    logic                   found;
    idx_t                   pick;
    int unsigned            cand;
    logic                   done_ack;
    logic                   done_err;
    logic                   active;

    logic [NUM_MASTERS-1:0]            ack_vec;
    logic [NUM_MASTERS-1:0]            err_vec;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] data_vec;

    assign req    = wb_io.m_cyc_i & wb_io.m_stb_i;
    assign active = (state_q == StActive);

    // Search starts one past the last grant, so the last winner has lowest priority.
    always_comb begin
        found = 1'b0;
        pick  = last_q;
        cand  = 0;
        for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
            cand = (32'(last_q) + k) % NUM_MASTERS;
            if (!found && req[idx_t'(cand)]) begin
                found = 1'b1;
                pick  = idx_t'(cand);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        sel_d    = sel_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        done_ack = 1'b0;
        done_err = 1'b0;

        case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d = pick;
                    last_d  = pick;
                    we_d    = wb_io.m_we_i[pick];
                    sel_d   = wb_io.m_sel_i[pick*SEL_WIDTH +: SEL_WIDTH];
                    addr_d  = wb_io.m_addr_i[pick*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d = wb_io.m_data_i[pick*DATA_WIDTH +: DATA_WIDTH];
                    cnt_d   = '0;
                    state_d = StActive;
                end
            end
            StActive: begin
                // A master dropping cyc abandons the transfer; it outranks a late ack.
                if (!wb_io.m_cyc_i[grant_q]) begin
                    state_d = StIdle;
                end else if (wb_io.s_ack_i) begin
                    done_ack = 1'b1;
                    ack_d    = 1'b1;
                    rdata_d  = wb_io.s_data_i;
                    state_d  = (RESP_REG != 0) ? StResp : StIdle;
                end else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    done_err = 1'b1;
                    err_d    = 1'b1;
                    rdata_d  = '0;
                    state_d  = (RESP_REG != 0) ? StResp : StIdle;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= idx_t'(NUM_MASTERS - 1);
            cnt_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // Unregistered mode answers in the ack cycle itself; registered mode answers from StResp.
    always_comb begin
        ack_vec  = '0;
        err_vec  = '0;
        data_vec = '0;
        if (RESP_REG == 0) begin
            ack_vec[grant_q] = done_ack;
            err_vec[grant_q] = done_err;
            if (done_ack) begin
                data_vec[grant_q*DATA_WIDTH +: DATA_WIDTH] = wb_io.s_data_i;
            end
        end else if (state_q == StResp) begin
            ack_vec[grant_q] = ack_q;
            err_vec[grant_q] = err_q;
            data_vec[grant_q*DATA_WIDTH +: DATA_WIDTH] = rdata_q;
        end
    end

    assign wb_io.m_ack_o  = ack_vec;
    assign wb_io.m_err_o  = err_vec;
    assign wb_io.m_data_o = data_vec;

    assign wb_io.s_cyc_o  = active;
    assign wb_io.s_stb_o  = active;
    assign wb_io.s_we_o   = active & we_q;
    assign wb_io.s_sel_o  = active ? sel_q : '0;
    assign wb_io.s_addr_o = active ? addr_q : '0;
    assign wb_io.s_data_o = active ? wdata_q : '0;
endmodule

// File: tb/tb_wb_core_arbiter.sv
// Bench for wb_core_arbiter: one instance without and one with the registered response path,
// a scripted slave, a response scoreboard, a vector table and hand-written corner sequences.
module tb_wb_core_arbiter;
    localparam int unsigned NM  = 2;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = 4;
    localparam int unsigned TMO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_core_arbiter_if #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if0 ();
    wb_core_arbiter_if #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();

    wb_core_arbiter #(
        .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_REG(0), .TIMEOUT_CYCLES(TMO)
    ) dut0 (
        .clk_core (clk),
        .rst_core (rst),
        .wb_io    (if0.slave)
    );

    wb_core_arbiter #(
        .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_REG(1), .TIMEOUT_CYCLES(TMO)
    ) dut1 (
        .clk_core (clk),
        .rst_core (rst),
        .wb_io    (if1.slave)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          m;
        bit          err;
        logic [31:0] data;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    typedef struct {
        int          d;
        int          m;
        bit          we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rdata;
    } vec_t;
    vec_t vecs[9];

    // Slave script per instance: ack after sl_delay ACTIVE cycles (negative = never).
    int          sl_delay[2];
    logic [31:0] sl_rdata[2];
    int          sl_cnt[2];
    logic [4:0]  cap_wsel[2];
    logic [31:0] cap_addr[2];
    logic [31:0] cap_data[2];

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int d, input int m, input bit err, input logic [31:0] data);
        exp_t x;
        x.m = m;
        x.err = err;
        x.data = err ? 32'h0 : data;
        if (d == 0) q0.push_back(x);
        else q1.push_back(x);
    endtask

    task automatic set_m(input int d, input int m, input bit cyc, input bit stb, input bit we,
                         input logic [3:0] sel, input logic [31:0] addr, input logic [31:0] data);
        if (d == 0) begin
            if0.m_cyc_i[m +: 1] = cyc;
            if0.m_stb_i[m +: 1] = stb;
            if0.m_we_i[m +: 1] = we;
            if0.m_sel_i[m*SW +: SW] = sel;
            if0.m_addr_i[m*AW +: AW] = addr;
            if0.m_data_i[m*DW +: DW] = data;
        end else begin
            if1.m_cyc_i[m +: 1] = cyc;
            if1.m_stb_i[m +: 1] = stb;
            if1.m_we_i[m +: 1] = we;
            if1.m_sel_i[m*SW +: SW] = sel;
            if1.m_addr_i[m*AW +: AW] = addr;
            if1.m_data_i[m*DW +: DW] = data;
        end
    endtask

    function automatic bit evt(input int d, input int m);
        logic [NM-1:0] v;
        v = (d == 0) ? (if0.m_ack_o | if0.m_err_o) : (if1.m_ack_o | if1.m_err_o);
        if (m < 0) return |v;
        v = v >> m;
        return v[0];
    endfunction

    function automatic logic [71:0] sbus(input int d);
        if (d == 0)
            return 72'({if0.s_cyc_o, if0.s_stb_o, if0.s_we_o, if0.s_sel_o, if0.s_addr_o, if0.s_data_o});
        return 72'({if1.s_cyc_o, if1.s_stb_o, if1.s_we_o, if1.s_sel_o, if1.s_addr_o, if1.s_data_o});
    endfunction

    function automatic logic [71:0] mbus(input int d);
        if (d == 0) return 72'({if0.m_ack_o, if0.m_err_o, if0.m_data_o});
        return 72'({if1.m_ack_o, if1.m_err_o, if1.m_data_o});
    endfunction

    task automatic wait_done(input int d, input int m, input string name, output int lat);
        lat = -1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (evt(d, m)) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no ack/err within 24 cycles, expected a response", name);
        end
    endtask

    task automatic slave_step(input int d);
        logic stb;
        logic ack;
        stb = (d == 0) ? if0.s_stb_o : if1.s_stb_o;
        ack = 1'b0;
        if (stb) begin
            if (sl_cnt[d] == 0) begin
                cap_wsel[d] = (d == 0) ? {if0.s_we_o, if0.s_sel_o} : {if1.s_we_o, if1.s_sel_o};
                cap_addr[d] = (d == 0) ? if0.s_addr_o : if1.s_addr_o;
                cap_data[d] = (d == 0) ? if0.s_data_o : if1.s_data_o;
            end
            ack = (sl_delay[d] >= 0) && (sl_cnt[d] == sl_delay[d]);
            sl_cnt[d]++;
        end else begin
            sl_cnt[d] = 0;
        end
        if (d == 0) begin
            if0.s_ack_i = ack;
            if0.s_data_i = ack ? sl_rdata[0] : ~sl_rdata[0];
        end else begin
            if1.s_ack_i = ack;
            if1.s_data_i = ack ? sl_rdata[1] : ~sl_rdata[1];
        end
    endtask

    initial begin
        if0.s_ack_i = 1'b0;
        if1.s_ack_i = 1'b0;
        if0.s_data_i = '0;
        if1.s_data_i = '0;
        forever begin
            @(posedge clk);
            #1;
            slave_step(0);
            slave_step(1);
        end
    end

    task automatic mon(input int d);
        logic [NM-1:0]    a, e, ea, ee;
        logic [NM*DW-1:0] dv, ed;
        exp_t             x;
        a  = (d == 0) ? if0.m_ack_o : if1.m_ack_o;
        e  = (d == 0) ? if0.m_err_o : if1.m_err_o;
        dv = (d == 0) ? if0.m_data_o : if1.m_data_o;
        if (a != 0 || e != 0) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected dut%0d: ack=%b err=%b, expected no response", d, a, e);
            end else begin
                if (d == 0) x = q0.pop_front();
                else x = q1.pop_front();
                ea = '0;
                ee = '0;
                ed = '0;
                if (x.err) ee[x.m +: 1] = 1'b1;
                else begin
                    ea[x.m +: 1] = 1'b1;
                    ed[x.m*DW +: DW] = x.data;
                end
                chk($sformatf("sb_ack_dut%0d", d), 72'(a), 72'(ea));
                chk($sformatf("sb_err_dut%0d", d), 72'(e), 72'(ee));
                chk($sformatf("sb_data_dut%0d", d), 72'(dv), 72'(ed));
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        mon(0);
        mon(1);
    end

    task automatic run_vec(input int i);
        vec_t v;
        bit   err;
        int   exp_lat;
        int   lat;
        v = vecs[i];
        err = (v.delay < 0) || (v.delay + 1 > int'(TMO));
        exp_lat = (err ? int'(TMO) : v.delay + 1) + v.d;
        @(posedge clk);
        #1;
        sl_delay[v.d] = v.delay;
        sl_rdata[v.d] = v.rdata;
        cap_wsel[v.d] = 'x;
        cap_addr[v.d] = 'x;
        cap_data[v.d] = 'x;
        push(v.d, v.m, err, v.rdata);
        set_m(v.d, v.m, 1'b1, 1'b1, v.we, v.sel, v.addr, v.wdata);
        wait_done(v.d, v.m, $sformatf("vec%0d_wait", i), lat);
        chk($sformatf("vec%0d_latency", i), 72'(lat), 72'(exp_lat));
        chk($sformatf("vec%0d_s_we_sel_addr", i), 72'({cap_wsel[v.d], cap_addr[v.d]}),
            72'({v.we, v.sel, v.addr}));
        chk($sformatf("vec%0d_s_data", i), 72'(cap_data[v.d]), 72'(v.wdata));
        @(posedge clk);
        #1;
        set_m(v.d, v.m, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk($sformatf("vec%0d_s_cyc_low", i), 72'(sbus(v.d) >> 70), 72'(0));
    endtask

    initial begin
        int lat;
        bit seen;
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        bit seen;
        vecs[0] = '{0, 0, 1'b0, 4'hF, 32'h100, 32'h0,        2, 32'hDEADBEEF};
        vecs[1] = '{0, 1, 1'b1, 4'h3, 32'h200, 32'h12345678, 0, 32'h0};
        vecs[2] = '{1, 1, 1'b1, 4'h3, 32'h300, 32'h12345678, 0, 32'h0};
        vecs[3] = '{1, 0, 1'b0, 4'hF, 32'h400, 32'h0,        1, 32'hCAFEF00D};
        vecs[4] = '{0, 1, 1'b0, 4'hF, 32'h104, 32'h0,       -1, 32'h0};
        vecs[5] = '{1, 0, 1'b0, 4'hC, 32'h108, 32'h0,       -1, 32'h0};
        vecs[6] = '{0, 0, 1'b0, 4'hF, 32'h10C, 32'h0,        3, 32'hA5A5A5A5};
        vecs[7] = '{1, 1, 1'b0, 4'hF, 32'h110, 32'h0,        3, 32'h5A5A5A5A};
        vecs[8] = '{0, 1, 1'b0, 4'hF, 32'h114, 32'h0,        4, 32'h77777777};
        sl_delay[0] = -1;
        sl_delay[1] = -1;
        sl_rdata[0] = '0;
        sl_rdata[1] = '0;
        sl_cnt[0] = 0;
        sl_cnt[1] = 0;
        for (int d = 0; d < 2; d++) begin
            for (int m = 0; m < int'(NM); m++) begin
                set_m(d, m, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            end
        end

        repeat (3) @(negedge clk);
        chk("reset_sbus_dut0", sbus(0), 72'(0));
        chk("reset_mbus_dut0", mbus(0), 72'(0));
        chk("reset_sbus_dut1", sbus(1), 72'(0));
        chk("reset_mbus_dut1", mbus(1), 72'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Both masters saturate the bus: grants alternate starting with master 0.
        @(posedge clk);
        #1;
        sl_delay[0] = 0;
        sl_rdata[0] = 32'h11110000;
        push(0, 0, 1'b0, 32'h11110000);
        push(0, 1, 1'b0, 32'h11110000);
        push(0, 0, 1'b0, 32'h11110000);
        push(0, 1, 1'b0, 32'h11110000);
        set_m(0, 0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        set_m(0, 1, 1'b1, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
        for (int k = 0; k < 4; k++) begin
            wait_done(0, -1, $sformatf("rr%0d_wait", k), lat);
            chk($sformatf("rr%0d_spacing", k), 72'(lat), 72'(1));
        end
        @(posedge clk);
        #1;
        set_m(0, 0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_m(0, 1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

        for (int i = 0; i < 9; i++) run_vec(i);

        // Master 0 drops cyc in its second ACTIVE cycle.
        @(posedge clk);
        #1;
        sl_delay[0] = -1;
        set_m(0, 0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h600, 32'h0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        set_m(0, 0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("abort_cyc_in_drop_cycle", 72'(if0.s_cyc_o), 72'(1));
        @(negedge clk);
        chk("abort_cyc_next_cycle", 72'(if0.s_cyc_o), 72'(0));
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | evt(0, -1);
        end
        chk("abort_no_ack_err", 72'(seen), 72'(0));

        // Master inputs change after grant; the slave bus must keep the latched request.
        @(posedge clk);
        #1;
        sl_delay[1] = 3;
        sl_rdata[1] = 32'h0F0F0F0F;
        push(1, 0, 1'b0, 32'h0F0F0F0F);
        set_m(1, 0, 1'b1, 1'b1, 1'b1, 4'hF, 32'h500, 32'h55AA55AA);
        @(posedge clk);
        #1;
        set_m(1, 0, 1'b1, 1'b1, 1'b0, 4'h0, 32'hFFF, 32'h0);
        @(negedge clk);
        chk("hold_a1_ctrl", 72'({if1.s_we_o, if1.s_sel_o, if1.s_addr_o}), 72'({1'b1, 4'hF, 32'h500}));
        @(negedge clk);
        chk("hold_a2_data", 72'(if1.s_data_o), 72'(32'h55AA55AA));
        wait_done(1, 0, "hold_wait", lat);
        @(posedge clk);
        #1;
        set_m(1, 0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

        // Reset lands in the middle of a transfer on both instances.
        @(posedge clk);
        #1;
        sl_delay[0] = -1;
        sl_delay[1] = -1;
        set_m(0, 0, 1'b1, 1'b1, 1'b1, 4'hF, 32'h700, 32'h1);
        set_m(1, 1, 1'b1, 1'b1, 1'b1, 4'hF, 32'h800, 32'h2);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("pre_reset_active", 72'({if0.s_cyc_o, if1.s_cyc_o}), 72'(2'b11));
        #1;
        rst = 1'b1;
        #1;
        chk("midreset_sbus_dut0", sbus(0), 72'(0));
        chk("midreset_mbus_dut0", mbus(0), 72'(0));
        chk("midreset_sbus_dut1", sbus(1), 72'(0));
        chk("midreset_mbus_dut1", mbus(1), 72'(0));
        set_m(0, 0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_m(1, 1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Simultaneous requests after reset: master 0 wins first.
        @(posedge clk);
        #1;
        sl_delay[0] = 0;
        sl_rdata[0] = 32'h22220000;
        push(0, 0, 1'b0, 32'h22220000);
        push(0, 1, 1'b0, 32'h22220000);
        set_m(0, 0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h900, 32'h0);
        set_m(0, 1, 1'b1, 1'b1, 1'b0, 4'hF, 32'hA00, 32'h0);
        wait_done(0, -1, "post_reset_first_wait", lat);
        chk("post_reset_winner", 72'(if0.m_ack_o), 72'(2'b01));
        chk("post_reset_latency", 72'(lat), 72'(1));
        wait_done(0, -1, "post_reset_second_wait", lat);
        @(posedge clk);
        #1;
        set_m(0, 0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_m(0, 1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

        repeat (4) @(negedge clk);
        chk("sb_drained_dut0", 72'(q0.size()), 72'(0));
        chk("sb_drained_dut1", 72'(q1.size()), 72'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
